rf_write_queue: RTL and testbench

RF_WRITE_QUEUE -- requirements
Module: rf_write_queue

---
 rtl/rf_pkg.sv | 10 +
 rtl/wq_fifo.sv | 58 +++++
 rtl/rf_write_queue.sv | 94 +++++++++
 tb/tb_rf_write_queue.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared widths and the queued write entry for the register-file write queue.
package rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] wd;
  } wq_entry_t;
endpackage

// File: rtl/wq_fifo.sv
// Storage, pointers and occupancy for the write queue. It accepts up to two
// enqueues per cycle (enq0 older than enq1) and dequeues one entry every cycle while non-empty.
module wq_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enq0_vld,
  input  wq_entry_t     enq0,
  input  logic          enq1_vld,
  input  wq_entry_t     enq1,
  output wq_entry_t     head,
  output logic [CW-1:0] count,
  output logic [PW-1:0] rd_ptr,
  output wq_entry_t     ent [DEPTH]
);
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, wa1;
  logic [CW-1:0] count_reg, n_enq;
  logic          deq;
  wq_entry_t     mem_reg [DEPTH];

  assign deq   = (count_reg != '0);
  assign n_enq = CW'(enq0_vld) + CW'(enq1_vld);
  assign wa1   = wr_ptr_reg + PW'(enq0_vld);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      count_reg  <= count_reg + n_enq - CW'(deq);
      wr_ptr_reg <= wr_ptr_reg + PW'(n_enq);
      rd_ptr_reg <= rd_ptr_reg + PW'(deq);
    end
  end

  // Entry storage is deliberately not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (enq0_vld) mem_reg[wr_ptr_reg] <= enq0;
    if (enq1_vld) mem_reg[wa1] <= enq1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      assign ent[gi] = mem_reg[gi];
    end
  endgenerate

  assign head   = mem_reg[rd_ptr_reg];
  assign count  = count_reg;
  assign rd_ptr = rd_ptr_reg;
endmodule

// File: rtl/rf_write_queue.sv
// Two-source (load, ALU) register-file write queue with one write per cycle.
// Optional pending-write bypass lookup is built when RF_WQ_BYPASS_EN is defined.
module rf_write_queue
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ld_vld,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [REG_DATA_W-1:0] ld_wd,
  output logic                  ld_rdy,
  input  logic                  alu_vld,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [REG_DATA_W-1:0] alu_wd,
  output logic                  alu_rdy,
  output logic                  rf_wr,
  output logic [REG_ADDR_W-1:0] rf_a3,
  output logic [REG_DATA_W-1:0] rf_wd,
  input  logic [REG_ADDR_W-1:0] byp_a,
  output logic                  byp_hit,
  output logic [REG_DATA_W-1:0] byp_d
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] count, free_slots;
  logic [PW-1:0] rd_ptr;
  logic          ld_take, alu_take;
  wq_entry_t     ld_ent, alu_ent, head;
  wq_entry_t     ent [DEPTH];

  assign free_slots = CW'(DEPTH) - count;
  assign ld_rdy     = (count < CW'(DEPTH));
  // A load with rd=0 is accepted but consumes no slot, so it does not block the ALU.
  assign ld_take    = ld_vld & ld_rdy & (ld_rd != '0);
  assign alu_rdy    = (free_slots >= (CW'(1) + CW'(ld_take)));
  assign alu_take   = alu_vld & alu_rdy & (alu_rd != '0);

  assign ld_ent  = '{rd: ld_rd, wd: ld_wd};
  assign alu_ent = '{rd: alu_rd, wd: alu_wd};

  wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .enq0_vld (ld_take | alu_take),
    .enq0     (ld_take ? ld_ent : alu_ent),
    .enq1_vld (ld_take & alu_take),
    .enq1     (alu_ent),
    .head     (head),
    .count    (count),
    .rd_ptr   (rd_ptr),
    .ent      (ent)
  );

  assign rf_wr = (count != '0);
  assign rf_a3 = rf_wr ? head.rd : '0;
  assign rf_wd = rf_wr ? head.wd : '0;

`ifdef RF_WQ_BYPASS_EN
  wq_entry_t       ord [DEPTH];
  logic [DEPTH-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_byp
      // ord[0] is the head (oldest); higher offsets are younger.
      assign ord[gi]   = ent[rd_ptr + PW'(gi)];
      assign match[gi] = (CW'(gi) < count) && (ord[gi].rd == byp_a) && (byp_a != '0);
    end
  endgenerate

  always_comb begin
    byp_hit = 1'b0;
    byp_d   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k]) begin
        byp_hit = 1'b1;
        byp_d   = ord[k].wd;
      end
    end
  end
`else
  logic unused_byp;
  always_comb begin
    unused_byp = ^{byp_a, rd_ptr};
    for (int k = 0; k < DEPTH; k++) unused_byp = unused_byp ^ (^ent[k]);
  end

  assign byp_hit = 1'b0;
  assign byp_d   = '0;
`endif
endmodule

// File: tb/tb_rf_write_queue.sv
// Randomized and directed bench for rf_write_queue against a queue-based reference model.
module tb_rf_write_queue;
  import rf_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ld_vld = 1'b0, alu_vld = 1'b0;
  logic [4:0]  ld_rd = '0, alu_rd = '0, byp_a = '0;
  logic [31:0] ld_wd = '0, alu_wd = '0;
  logic        ld_rdy, alu_rdy, rf_wr, byp_hit;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd, byp_d;

  rf_write_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .ld_vld(ld_vld), .ld_rd(ld_rd), .ld_wd(ld_wd), .ld_rdy(ld_rdy),
    .alu_vld(alu_vld), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_rdy(alu_rdy),
    .rf_wr(rf_wr), .rf_a3(rf_a3), .rf_wd(rf_wd),
    .byp_a(byp_a), .byp_hit(byp_hit), .byp_d(byp_d)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  wq_entry_t   q[$];
  logic        alu_accepted;
  logic        obs_ld_rdy, obs_alu_rdy, obs_byp_hit;
  logic [31:0] obs_byp_d;
  logic [4:0]  last_wr_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Youngest pending write to a register, straight from the queue contents.
  function automatic void byp_model(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
`ifdef RF_WQ_BYPASS_EN
    if (a != 0)
      foreach (q[i])
        if (q[i].rd == a) begin
          h = 1'b1;
          d = q[i].wd;
        end
`else
    if (a != 0) h = 1'b0;
`endif
  endfunction

  // Called just after a falling edge: drive, check, advance through one rising edge.
  task automatic step(input logic lv, input logic [4:0] lr, input logic [31:0] lw,
                      input logic av, input logic [4:0] ar, input logic [31:0] aw,
                      input logic [4:0] ba);
    int          sz;
    logic        e_ld_rdy, e_ld_take, e_alu_rdy, e_hit;
    logic [31:0] e_d;
    ld_vld = lv; ld_rd = lr; ld_wd = lw;
    alu_vld = av; alu_rd = ar; alu_wd = aw;
    byp_a = ba;
    #1;
    sz        = q.size();
    e_ld_rdy  = (sz < DEPTH);
    e_ld_take = lv && e_ld_rdy && (lr != 0);
    e_alu_rdy = ((DEPTH - sz) >= (1 + (e_ld_take ? 1 : 0)));
    byp_model(ba, e_hit, e_d);
    check("ld_rdy", ld_rdy, e_ld_rdy);
    check("alu_rdy", alu_rdy, e_alu_rdy);
    check("rf_wr", rf_wr, sz > 0);
    check("rf_a3", rf_a3, sz > 0 ? q[0].rd : 5'd0);
    check("rf_wd", rf_wd, sz > 0 ? q[0].wd : 32'd0);
    check("byp_hit", byp_hit, e_hit);
    check("byp_d", byp_d, e_d);
    obs_ld_rdy = ld_rdy; obs_alu_rdy = alu_rdy;
    obs_byp_hit = byp_hit; obs_byp_d = byp_d;
    if (rf_wr) begin
      last_wr_rd = rf_a3;
      $display("t=%0t rf write r%0d = 0x%08h", $time, rf_a3, rf_wd);
    end
    alu_accepted = av && e_alu_rdy;
    @(posedge clk);
    if (sz > 0) void'(q.pop_front());
    if (e_ld_take) q.push_back('{rd: lr, wd: lw});
    if (av && e_alu_rdy && ar != 0) q.push_back('{rd: ar, wd: aw});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset: rdy asserted even with a load pending, everything else quiet.
    ld_vld = 1'b1; ld_rd = 5'd3;
    #1;
    check("rst_rf_wr", rf_wr, 0);
    check("rst_rf_a3", rf_a3, 0);
    check("rst_rf_wd", rf_wd, 0);
    check("rst_ld_rdy", ld_rdy, 1);
    check("rst_alu_rdy", alu_rdy, 1);
    check("rst_byp_hit", byp_hit, 0);
    check("rst_byp_d", byp_d, 0);
    ld_vld = 1'b0;
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;

    // Single ALU write appears next cycle for exactly one cycle.
    step(0, 0, 0, 1, 5'd5, 32'h1234, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("req034_rd", last_wr_rd, 5);
    idle(1);

    // Simultaneous load + ALU: load first.
    step(1, 5'd3, 32'hAAAA, 1, 5'd4, 32'hBBBB, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("req035_first", last_wr_rd, 3);
    step(0, 0, 0, 0, 0, 0, 0);
    check("req035_second", last_wr_rd, 4);
    idle(1);

    // Build count=3, then ALU is held off while the load goes in.
    step(1, 5'd1, 32'h10, 1, 5'd2, 32'h20, 0);
    step(1, 5'd3, 32'h30, 1, 5'd4, 32'h40, 0);
    step(1, 5'd5, 32'h55, 1, 5'd7, 32'h77, 0);
    check("req036_ld_rdy", obs_ld_rdy, 1);
    check("req036_alu_rdy", obs_alu_rdy, 0);
    begin
      int tries = 0;
      alu_accepted = 1'b0;
      while (!alu_accepted && tries < 8) begin
        step(0, 0, 0, 1, 5'd7, 32'h77, 0);
        tries++;
      end
      check("req036_alu_accept_timeout", alu_accepted, 1);
    end
    idle(DEPTH + 1);
    check("req036_last_rd", last_wr_rd, 7);

    // rd=0 accepted, never written.
    step(0, 0, 0, 1, 5'd0, 32'hFFFF, 0);
    check("req037_alu_rdy", obs_alu_rdy, 1);
    idle(2);

    // Bypass: youngest of two pending r6 writes.
    step(1, 5'd6, 32'h11, 1, 5'd6, 32'h22, 0);
    step(0, 0, 0, 0, 0, 0, 5'd6);
`ifdef RF_WQ_BYPASS_EN
    check("req038_hit", obs_byp_hit, 1);
    check("req038_d", obs_byp_d, 32'h22);
`else
    check("req038_hit_off", obs_byp_hit, 0);
`endif
    step(0, 0, 0, 0, 0, 0, 5'd0);
    check("req038_a0_hit", obs_byp_hit, 0);
    idle(2);

    // Mid-operation reset discards pending entries immediately.
    step(1, 5'd8, 32'h80, 1, 5'd9, 32'h90, 0);
    step(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 0);
    rstn = 1'b0;
    #1;
    check("req039_rf_wr", rf_wr, 0);
    check("req039_ld_rdy", ld_rdy, 1);
    check("req039_rf_a3", rf_a3, 0);
    q.delete();
    @(negedge clk);
    rstn = 1'b1;
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)));
    end
    idle(DEPTH + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
